// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the master
// (drives stage information), the hazard controller is the slave.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);

  logic [4:0]             ID_rs;
  logic [4:0]             ID_rt;
  logic                   ID_UsesRs;
  logic                   ID_UsesRt;
  logic                   ID_Jump;
  logic                   ID_Eret;
  logic [4:0]             EX_rs;
  logic [4:0]             EX_rt;
  logic                   EX_RegWrite;
  logic                   EX_MemRead;
  logic [4:0]             EX_WriteAddress;
  logic                   EX_BranchTaken;
  logic                   MEM_RegWrite;
  logic [4:0]             MEM_WriteAddress;
  logic                   WB_RegWrite;
  logic [4:0]             WB_WriteAddress;
  logic                   irq;

  logic                   PC_Write;
  logic                   IF_ID_Write;
  logic                   IF_ID_Flush;
  logic                   ID_EX_Flush;
  logic [1:0]             ForwardA;
  logic [1:0]             ForwardB;
  logic                   Irq_Take;
  logic                   Irq_Active;
  logic [STALL_CNT_W-1:0] Stall_Count;

  modport master (
    output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Jump, ID_Eret,
    output EX_rs, EX_rt, EX_RegWrite, EX_MemRead, EX_WriteAddress, EX_BranchTaken,
    output MEM_RegWrite, MEM_WriteAddress, WB_RegWrite, WB_WriteAddress, irq,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    input  ForwardA, ForwardB, Irq_Take, Irq_Active, Stall_Count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Jump, ID_Eret,
    input  EX_rs, EX_rt, EX_RegWrite, EX_MemRead, EX_WriteAddress, EX_BranchTaken,
    input  MEM_RegWrite, MEM_WriteAddress, WB_RegWrite, WB_WriteAddress, irq,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    output ForwardA, ForwardB, Irq_Take, Irq_Active, Stall_Count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control and interrupt-entry sequencing for the five-stage pipeline.
// Define HAZARD_FWD_EN to build with EX operand forwarding; otherwise RAW hazards stall.
module pipeline_hazard_ctrl #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter logic [31:0] IRQ_VECTOR  = 32'h8000_0004
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TAKE   = 2'd2,
    ST_KERNEL = 2'd3
  } irq_state_e;

  irq_state_e             state_q;
  irq_state_e             state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;

  logic       load_use_s;
  logic       raw_stall_s;
  logic       stall_s;
  logic       busy_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       unused_s;

  logic       pc_write_s;
  logic       ifid_write_s;
  logic       ifid_flush_s;
  logic       idex_flush_s;
  logic       irq_take_s;
  logic       stall_win_s;

  function automatic logic reg_hit(
    input logic       uses,
    input logic [4:0] src,
    input logic       wen,
    input logic [4:0] dst
  );
    return uses && wen && (dst != 5'd0) && (src == dst);
  endfunction

  // MEM is younger than WB, so its result takes priority.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_we,
    input logic [4:0] mem_wa,
    input logic       wb_we,
    input logic [4:0] wb_wa
  );
    logic [1:0] sel;
    if (reg_hit(1'b1, src, mem_we, mem_wa)) begin
      sel = 2'b01;
    end else if (reg_hit(1'b1, src, wb_we, wb_wa)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign load_use_s = reg_hit(hz.ID_UsesRs, hz.ID_rs, hz.EX_MemRead, hz.EX_WriteAddress) |
                      reg_hit(hz.ID_UsesRt, hz.ID_rt, hz.EX_MemRead, hz.EX_WriteAddress);

`ifdef HAZARD_FWD_EN
  assign raw_stall_s = 1'b0;
  assign fwd_a_s     = fwd_sel(hz.EX_rs, hz.MEM_RegWrite, hz.MEM_WriteAddress,
                               hz.WB_RegWrite, hz.WB_WriteAddress);
  assign fwd_b_s     = fwd_sel(hz.EX_rt, hz.MEM_RegWrite, hz.MEM_WriteAddress,
                               hz.WB_RegWrite, hz.WB_WriteAddress);
  assign unused_s    = ^{IRQ_VECTOR, hz.EX_RegWrite};
`else
  // WB is bypassed inside the register file, so only EX and MEM producers stall.
  assign raw_stall_s = reg_hit(hz.ID_UsesRs, hz.ID_rs, hz.EX_RegWrite,  hz.EX_WriteAddress)  |
                       reg_hit(hz.ID_UsesRt, hz.ID_rt, hz.EX_RegWrite,  hz.EX_WriteAddress)  |
                       reg_hit(hz.ID_UsesRs, hz.ID_rs, hz.MEM_RegWrite, hz.MEM_WriteAddress) |
                       reg_hit(hz.ID_UsesRt, hz.ID_rt, hz.MEM_RegWrite, hz.MEM_WriteAddress);
  assign fwd_a_s     = 2'b00;
  assign fwd_b_s     = 2'b00;
  assign unused_s    = ^{IRQ_VECTOR, hz.EX_rs, hz.EX_rt, hz.WB_RegWrite, hz.WB_WriteAddress};
`endif

  assign stall_s = load_use_s | raw_stall_s;
  assign busy_s  = hz.EX_BranchTaken | stall_s;

  // Priority resolution of the pipeline-register controls; everything held low in reset.
  always_comb begin
    pc_write_s   = 1'b0;
    ifid_write_s = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    irq_take_s   = 1'b0;
    stall_win_s  = 1'b0;
    if (reset) begin
      pc_write_s = 1'b0;
    end else if (state_q == ST_TAKE) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
      irq_take_s   = 1'b1;
    end else if (hz.EX_BranchTaken) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (stall_s) begin
      idex_flush_s = 1'b1;
      stall_win_s  = 1'b1;
    end else if (hz.ID_Jump || hz.ID_Eret) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
    end else begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
    end
  end

  // Interrupt-entry next state: wait out branches/stalls, then take for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hz.irq) begin
          state_d = busy_s ? ST_DRAIN : ST_TAKE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!hz.irq) begin
          state_d = ST_IDLE;
        end else if (busy_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_TAKE;
        end
      end
      ST_TAKE: begin
        state_d = ST_KERNEL;
      end
      ST_KERNEL: begin
        if (hz.ID_Eret) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_KERNEL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_win_s && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.PC_Write    = pc_write_s;
  assign hz.IF_ID_Write = ifid_write_s;
  assign hz.IF_ID_Flush = ifid_flush_s;
  assign hz.ID_EX_Flush = idex_flush_s;
  assign hz.Irq_Take    = irq_take_s;
  assign hz.Irq_Active  = (state_q == ST_KERNEL);
  assign hz.ForwardA    = reset ? 2'b00 : fwd_a_s;
  assign hz.ForwardB    = reset ? 2'b00 : fwd_b_s;
  assign hz.Stall_Count = stall_cnt_q;

endmodule
